soi_capture: RTL and testbench
==============================

# soi_capture

Observation-side counterpart to the fault-injection target: samples a signal-of-interest (SOI) vector every cycle, records an entry only when a masked bit changes, and buffers entries in a FIFO. A DPI-facing host drains the FIFO over a valid/ready read port. The injection path writes values into the design; this block reads the design's response back out, with cycle timestamps and drop reporting.

## Interface
- SOI_W, 3, width of observed vector
- DEPTH, 8, FIFO entries; power of two, at least 2
- TS_W, 16, timestamp width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  capture enable
- soi  in  SOI_W  observed signals
- mask  in  SOI_W  per-bit change-detect enable; 1 = bit can trigger capture
- rd_ready  in  1  host accepts head entry
- rd_valid  out  1  FIFO non-empty
- rd_data  out  SOI_W  head entry SOI value
- rd_ts  out  TS_W  head entry timestamp
- rd_ovf  out  1  one or more entries were dropped immediately before this entry
- count  out  $clog2(DEPTH)+1  current occupancy
- drop_cnt  out  8  dropped-entry count, saturates at 255

## Operation
- FSM states:
  - IDLE: `enable`=0; no captures.
  - PRIME: the first cycle with `enable`=1; pushes one baseline entry unconditionally, then moves to RUN.
  - RUN: pushes an entry when `((soi ^ prev_q) & mask) != 0`.
- From PRIME or RUN, `enable`=0 returns to IDLE at the next edge. FIFO contents are retained, and the read port keeps working in every state.
- `prev_q` loads `soi` on every edge in PRIME and RUN, including when no push happens. In IDLE, `prev_q` holds its value.
- Entry contents: full unmasked `soi`, `ts_q` at the capture edge, and the `pend_ovf` flag.
- Timestamp `ts_q`:
  - Free-running; increments every cycle in every state.
  - Wraps from 2^TS_W-1 to 0 with no special marking.
- Pop occurs when `rd_valid && rd_ready`; `rd_ready` while empty has no effect.
- Push while full:
  - If a pop happens in the same cycle, the push is accepted and `count` is unchanged.
  - Otherwise the entry is dropped, `pend_ovf` is set, and `drop_cnt` increments (saturating at 255).
- Push while not full with a simultaneous pop: both take effect and `count` is unchanged.
- `pend_ovf` is written into the next accepted entry and cleared at that same edge.
- A pop of the last entry with no push makes the FIFO empty at the next edge.
- `rd_data`, `rd_ts` and `rd_ovf` are driven to 0 whenever `rd_valid`=0.

## Timing
- Reset (async assert, sync deassert at the first edge after release) forces:
  - state IDLE; `prev_q`, `ts_q`, pointers, `pend_ovf` = 0;
  - outputs `rd_valid`=0, `rd_data`=0, `rd_ts`=0, `rd_ovf`=0, `count`=0, `drop_cnt`=0.
- Reset mid-operation discards all FIFO contents and any pending overflow flag.
- Capture latency:
  - A `soi` change presented before edge k is pushed at edge k.
  - `rd_valid`, head data and `count` reflect the push after edge k, i.e. visible in cycle k+1.
- Pop is visible after the edge at which `rd_valid && rd_ready` is sampled. The next entry, or empty, appears in the following cycle, so back-to-back pops run at 1 entry/cycle.
- Raising `enable` at edge k takes the FSM to PRIME after edge k. The baseline entry is pushed at edge k+1 with timestamp `ts_q`(k+1).
- A change in the PRIME cycle produces only the baseline entry, not two entries.
- Head outputs are combinational from FIFO memory and the read pointer. There is no combinational path from any input to any output.

## Configuration
- SOI_CAPTURE_TIMESTAMP_EN, when defined:
  - timestamp counter and per-entry TS_W field are present;
  - `rd_ts` carries the capture timestamp.
- When undefined:
  - counter and storage are removed; FIFO width is SOI_W+1;
  - `rd_ts` is tied to 0;
  - all other behaviour is identical.

## Test plan
- Reset then `enable`=1, `soi`=3'b010, `mask`=3'b111, no pops -> exactly one baseline entry; `count`=1; `rd_data`=3'b010; `rd_ovf`=0.
- RUN, `mask`=3'b001, `soi` toggles bit 2 for 5 cycles, then bit 0 once to 3'b001 -> only one new entry, `rd_data`=3'b001, with `rd_ts` equal to the timestamp of its capture edge.
- DEPTH=8, `rd_ready`=0, 11 distinct changes after the baseline -> `count`=8, `drop_cnt`=4 (baseline + 7 accepted, 4 dropped). After one pop and one further change: the newest entry has `rd_ovf`=1 and every other entry has `rd_ovf`=0.
- Full FIFO with simultaneous push and pop (`rd_ready`=1) -> `count` stays 8, `drop_cnt` unchanged, and the new entry appears at the tail.
- TS_W=4, entries captured across the wrap -> `rd_ts` sequence 14, 15, 0, 1 in order; with the macro undefined, `rd_ts`=0 for all entries.
- Reset asserted while `count`=5 and `pend_ovf`=1 -> all outputs 0 immediately. After re-enable, the first entry has `rd_ovf`=0.

Source files
------------

// File: rtl/soi_capture.sv
// Change-triggered SOI capture into a FIFO drained over a valid/ready read port.
// Optional SOI_CAPTURE_TIMESTAMP_EN adds a free-running timestamp to every entry.
module soi_capture #(
  parameter int unsigned SOI_W = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [SOI_W-1:0]         soi,
  input  logic [SOI_W-1:0]         mask,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [SOI_W-1:0]         rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic                     rd_ovf,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef SOI_CAPTURE_TIMESTAMP_EN
  localparam int unsigned EW = SOI_W + TS_W + 1;
`else
  localparam int unsigned EW = SOI_W + 1;
`endif

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e           state_q;
  logic [SOI_W-1:0] prev_q;
  logic             pend_q;
  logic [CW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]    mem_q [DEPTH];

  logic          changed, push, pop, full, accept, drop;
  logic [EW-1:0] entry, head;

  assign changed = |((soi ^ prev_q) & mask);
  assign push    = (state_q == StPrime) || ((state_q == StRun) && changed);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == CW'(DEPTH));
  assign pop     = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign accept  = push && (!full || pop);
  assign drop    = push && full && !pop;

`ifdef SOI_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  assign entry = {pend_q, ts_q, soi};
  assign rd_ts = rd_valid ? head[SOI_W +: TS_W] : '0;
`else
  assign entry = {pend_q, soi};
  assign rd_ts = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      prev_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable) state_q <= StPrime;
        end
        StPrime, StRun: begin
          prev_q  <= soi;
          state_q <= enable ? StRun : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + CW'(1);
        pend_q   <= 1'b0;
      end else if (drop) begin
        pend_q <= 1'b1;
        if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end

  // Storage needs no reset: head outputs are gated by rd_valid.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= entry;
  end

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? head[SOI_W-1:0] : '0;
  assign rd_ovf   = rd_valid ? head[EW-1] : 1'b0;

endmodule

// File: tb/tb_soi_capture.sv
// Self-checking bench for soi_capture: directed table, corner sequences and
// randomized stimulus compared against a queue-based reference model.
module tb_soi_capture;

  localparam int SOI_W = 3;
  localparam int DEPTH = 8;
  localparam int TS_W  = 4;
`ifdef SOI_CAPTURE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [SOI_W-1:0] soi = '0;
  logic [SOI_W-1:0] mask = '0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [SOI_W-1:0] rd_data;
  logic [TS_W-1:0]  rd_ts;
  logic             rd_ovf;
  logic [3:0]       count;
  logic [7:0]       drop_cnt;

  int checks = 0;
  int failures = 0;

  soi_capture #(
    .SOI_W(SOI_W),
    .DEPTH(DEPTH),
    .TS_W (TS_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .soi     (soi),
    .mask    (mask),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_ts   (rd_ts),
    .rd_ovf  (rd_ovf),
    .count   (count),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of entries plus "edges since enable rose" phase.
  typedef struct {
    logic [SOI_W-1:0] soi;
    int               ts;
    logic             ovf;
  } ent_t;

  ent_t             q[$];
  logic [SOI_W-1:0] m_prev;
  int               m_phase, m_ts, m_drop;
  logic             m_pend;

  function automatic int tsx(int t);
    return TS_EN ? t : 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev  = '0;
    m_phase = 0;
    m_ts    = 0;
    m_drop  = 0;
    m_pend  = 1'b0;
  endtask

  task automatic model_edge();
    int   n;
    logic do_pop, do_push, is_full;
    ent_t e;
    n       = q.size();
    do_pop  = (n > 0) && rd_ready;
    is_full = (n == DEPTH);
    do_push = (m_phase == 1) || (m_phase == 2 && ((soi ^ m_prev) & mask) != 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (!is_full || do_pop) begin
        e.soi = soi;
        e.ts  = m_ts;
        e.ovf = m_pend;
        q.push_back(e);
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    if (m_phase > 0) m_prev = soi;
    m_phase = enable ? ((m_phase == 0) ? 1 : 2) : 0;
    m_ts    = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic compare_model();
    chk("valid", 32'(rd_valid), 32'(q.size() > 0));
    chk("count", 32'(count), 32'(q.size()));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (q.size() > 0) begin
      chk("data", 32'(rd_data), 32'(q[0].soi));
      chk("ts", 32'(rd_ts), 32'(tsx(q[0].ts)));
      chk("ovf", 32'(rd_ovf), 32'(q[0].ovf));
    end else begin
      chk("data_idle", 32'(rd_data), 32'd0);
      chk("ts_idle", 32'(rd_ts), 32'd0);
      chk("ovf_idle", 32'(rd_ovf), 32'd0);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_ts", 32'(rd_ts), 32'd0);
    chk("rst_ovf", 32'(rd_ovf), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  typedef struct {
    logic             en;
    logic [SOI_W-1:0] soi;
    logic [SOI_W-1:0] mask;
    logic             rdy;
    int               cnt;
    logic [SOI_W-1:0] data;
    int               ts;
  } vec_t;

  vec_t tbl[11];
  int   wexp[4];

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Baseline then masked toggles on bit 2, then a bit-0 change captured at ts 8.
    tbl[0]  = '{1'b1, 3'b010, 3'b111, 1'b0, 0, 3'b000, 0};
    tbl[1]  = '{1'b1, 3'b010, 3'b111, 1'b0, 1, 3'b010, 1};
    tbl[2]  = '{1'b1, 3'b010, 3'b001, 1'b0, 1, 3'b010, 1};
    tbl[3]  = '{1'b1, 3'b110, 3'b001, 1'b0, 1, 3'b010, 1};
    tbl[4]  = '{1'b1, 3'b010, 3'b001, 1'b0, 1, 3'b010, 1};
    tbl[5]  = '{1'b1, 3'b110, 3'b001, 1'b0, 1, 3'b010, 1};
    tbl[6]  = '{1'b1, 3'b010, 3'b001, 1'b0, 1, 3'b010, 1};
    tbl[7]  = '{1'b1, 3'b110, 3'b001, 1'b0, 1, 3'b010, 1};
    tbl[8]  = '{1'b1, 3'b001, 3'b001, 1'b0, 2, 3'b010, 1};
    tbl[9]  = '{1'b1, 3'b001, 3'b001, 1'b1, 1, 3'b001, 8};
    tbl[10] = '{1'b1, 3'b001, 3'b001, 1'b0, 1, 3'b001, 8};
    wexp = '{14, 15, 0, 1};

    model_reset();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      enable   = tbl[i].en;
      soi      = tbl[i].soi;
      mask     = tbl[i].mask;
      rd_ready = tbl[i].rdy;
      tick();
      chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl_valid", 32'(rd_valid), 32'(tbl[i].cnt > 0));
      if (tbl[i].cnt > 0) begin
        chk("tbl_data", 32'(rd_data), 32'(tbl[i].data));
        chk("tbl_ts", 32'(rd_ts), 32'(tsx(tbl[i].ts)));
        chk("tbl_ovf", 32'(rd_ovf), 32'd0);
      end
    end

    // Overflow: baseline + 11 changes with no pops.
    enable = 1'b0;
    rd_ready = 1'b0;
    do_reset();
    enable = 1'b1;
    soi = 3'd0;
    mask = 3'b111;
    tick();
    tick();
    for (int k = 1; k <= 11; k++) begin
      soi = 3'(k % 8);
      tick();
    end
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_drop", 32'(drop_cnt), 32'd4);
    rd_ready = 1'b1;
    tick();
    chk("ovf_pop_count", 32'(count), 32'd7);
    rd_ready = 1'b0;
    soi = 3'd5;
    tick();
    chk("ovf_refill", 32'(count), 32'd8);
    rd_ready = 1'b1;
    soi = 3'd6;
    tick();
    chk("pushpop_count", 32'(count), 32'd8);
    chk("pushpop_drop", 32'(drop_cnt), 32'd4);
    for (int i = 0; i < 8; i++) begin
      chk("drain_ovf", 32'(rd_ovf), 32'(i == 6));
      if (i == 7) chk("drain_tail", 32'(rd_data), 32'd6);
      tick();
    end
    chk("drain_empty", 32'(rd_valid), 32'd0);

    // Timestamp wrap: capture at ts 14, 15, 0, 1.
    enable = 1'b0;
    rd_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 13; i++) tick();
    enable = 1'b1;
    soi = 3'd0;
    tick();
    tick();
    for (int k = 1; k <= 3; k++) begin
      soi = 3'(k);
      tick();
    end
    enable = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_ts", 32'(rd_ts), 32'(tsx(wexp[i])));
      tick();
    end

    // Reset with count=5 and a pending overflow flag.
    rd_ready = 1'b0;
    do_reset();
    enable = 1'b1;
    soi = 3'd0;
    tick();
    tick();
    for (int k = 1; k <= 9; k++) begin
      soi = 3'(k % 8);
      tick();
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_count", 32'(count), 32'd5);
    rd_ready = 1'b0;
    enable = 1'b0;
    do_reset();
    enable = 1'b1;
    soi = 3'd2;
    tick();
    tick();
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_ovf", 32'(rd_ovf), 32'd0);
    chk("post_rst_data", 32'(rd_data), 32'd2);

    // Randomized traffic against the model.
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      soi      = 3'($urandom);
      mask     = 3'($urandom);
      rd_ready = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
